// File: rtl/cla_pipe_addsub_if.sv
// Stream bundle for the pipelined CLA adder/subtractor: operand side and result side.
interface cla_pipe_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH bits split into STAGES registered
// carry segments, each built from 4-bit lookahead groups, with carry/overflow/zero flags.
module cla_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  cla_pipe_addsub_if.slave  bus
);

  localparam int SEG  = (STAGES > 0) ? WIDTH / STAGES : 4;
  localparam int GRPS = SEG / 4;

  generate
    if ((STAGES < 1) || (WIDTH % 4 != 0) || (STAGES > WIDTH / 4) ||
        (WIDTH % (4 * STAGES) != 0)) begin : g_bad_param
      $error("cla_pipe_addsub: illegal WIDTH/STAGES combination");
    end
  endgenerate

  // Returns {carry into segment MSB, segment carry-out, segment sum}.
  function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG:0]   c;
    logic [3:0]     p4;
    logic [3:0]     g4;
    logic           c0;
    logic           gg;
    logic           pg;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int k = 0; k < GRPS; k++) begin
      p4 = p[4*k +: 4];
      g4 = g[4*k +: 4];
      c0 = c[4*k];
      c[4*k+1] = g4[0] | (p4[0] & c0);
      c[4*k+2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c0);
      c[4*k+3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0]) |
                 (p4[2] & p4[1] & p4[0] & c0);
      gg = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) |
           (p4[3] & p4[2] & p4[1] & g4[0]);
      pg = &p4;
      c[4*k+4] = gg | (pg & c0);
    end
    return {c[SEG-1], c[SEG], p ^ c[SEG-1:0]};
  endfunction

  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] s_p   [STAGES];
  logic             c_p   [STAGES];
  logic             vld_p [STAGES];
  logic             ovf_p;
  logic             zero_p;

  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic             c_in  [STAGES];
  logic [WIDTH-1:0] s_nxt [STAGES];
  logic [SEG+1:0]   seg_r [STAGES];
  logic             adv;

  assign adv          = ~vld_p[STAGES-1] | bus.out_ready;
  assign bus.in_ready = adv & ~rst;

  // Stage k consumes segment k of its skewed operands and merges the result
  // into the sum bits already produced by earlier stages.
  always_comb begin
    a_in[0] = bus.a;
    b_in[0] = bus.sub ? ~bus.b : bus.b;
    c_in[0] = bus.sub | bus.cin;
    s_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_p[k-1];
      b_in[k] = b_p[k-1];
      c_in[k] = c_p[k-1];
      s_in[k] = s_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_r[k] = cla_seg(a_in[k][k*SEG +: SEG], b_in[k][k*SEG +: SEG], c_in[k]);
      s_nxt[k] = s_in[k];
      s_nxt[k][k*SEG +: SEG] = seg_r[k][SEG-1:0];
    end
  end

  // Stage boundary registers; reset clears valids and the visible result only.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_p[k] <= a_in[k];
        b_p[k] <= b_in[k];
        s_p[k] <= s_nxt[k];
        c_p[k] <= seg_r[k][SEG];
      end
      ovf_p  <= seg_r[STAGES-1][SEG+1] ^ seg_r[STAGES-1][SEG];
      zero_p <= (s_nxt[STAGES-1] == '0);
    end
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= 1'b0;
      end
      s_p[STAGES-1] <= '0;
      c_p[STAGES-1] <= 1'b0;
      ovf_p         <= 1'b0;
      zero_p        <= 1'b0;
    end else if (adv) begin
      vld_p[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  assign bus.out_valid = vld_p[STAGES-1];
  assign bus.sum       = s_p[STAGES-1];
  assign bus.cout      = c_p[STAGES-1];
  assign bus.ovf       = ovf_p;
  assign bus.zero      = zero_p;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub: directed corner cases, stall/stream ordering and
// reset flush on a 32x4 instance, plus random model comparison on five other shapes.
module tb_cla_pipe_addsub;

  logic clk = 1'b0;
  logic rst;
  logic rst_x;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int done_x = 0;

  localparam int NX         = 5;
  localparam int N_OPS_X    = 10000;
  localparam int CFG_W [NX] = '{32, 32, 32, 16, 64};
  localparam int CFG_S [NX] = '{1, 2, 8, 4, 4};

  task automatic chk_eq(input string tag, input logic [66:0] got, input logic [66:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Behavioural reference in plain integer arithmetic: {sum, cout, ovf, zero}.
  function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic ci, input logic sb, input int w);
    logic [64:0] mask;
    logic [64:0] aa;
    logic [64:0] bb;
    logic [64:0] full;
    logic [63:0] s;
    logic        co;
    logic        ov;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & mask;
    bb   = (sb ? ~{1'b0, b} : {1'b0, b}) & mask;
    full = aa + bb + {64'd0, (sb ? 1'b1 : ci)};
    s    = full[63:0] & mask[63:0];
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {s, co, ov, (s == 64'd0)};
  endfunction

  function automatic logic [63:0] rnd64(input int w);
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return (64'd1 << (w - 1)) - 64'd1;
      3:       return 64'd1 << (w - 1);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [66:0] pk(input logic [63:0] s, input logic c,
                                     input logic o, input logic z);
    return {s, c, o, z};
  endfunction

  // ---------------- main 32x4 instance ----------------
  cla_pipe_addsub_if #(.WIDTH(32)) bus ();
  cla_pipe_addsub #(.WIDTH(32), .STAGES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [66:0] exp_q [$];

  function automatic logic [66:0] obs_main();
    return pk({32'd0, bus.sum}, bus.cout, bus.ovf, bus.zero);
  endfunction

  // Output monitor: retire compare, and stall-hold stability.
  initial begin
    logic        prev_stall;
    logic [66:0] prev_obs;
    logic [66:0] o;
    prev_stall = 1'b0;
    prev_obs   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        o = obs_main();
        if (prev_stall) chk_eq("stall_hold", {bus.out_valid, o[65:0]}, {1'b1, prev_obs[65:0]});
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) chk_eq("spurious_out", {66'd0, bus.out_valid}, 67'd0);
          else chk_eq("result", o, exp_q.pop_front());
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_obs   = o;
      end
    end
  end

  task automatic send_lat(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb, input logic [66:0] exp);
    int lat;
    @(posedge clk); #1;
    bus.a = a; bus.b = b; bus.cin = ci; bus.sub = sb;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_eq({tag, "_latency"}, 67'(lat), 67'd4);
    @(posedge clk); #1;
  endtask

  initial begin
    int          sent;
    int          cyc;
    int          stale;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic        rs;
    rst = 1'b1; rst_x = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_out_valid", {66'd0, bus.out_valid}, 67'd0);
    chk_eq("rst_in_ready", {66'd0, bus.in_ready}, 67'd0);
    chk_eq("rst_flags", obs_main(), 67'd0);
    @(posedge clk); #1;
    rst = 1'b0; rst_x = 1'b0;
    @(negedge clk);
    chk_eq("in_ready_after_rst", {66'd0, bus.in_ready}, 67'd1);

    send_lat("ovf_add", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, pk(64'h8000_0000, 1'b0, 1'b1, 1'b0));
    send_lat("sub_neg", 32'd5, 32'd7, 1'b1, 1'b1, pk(64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    send_lat("ovf_sub", 32'h8000_0000, 32'd1, 1'b0, 1'b1, pk(64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    send_lat("carry_all", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, pk(64'd0, 1'b1, 1'b0, 1'b1));
    send_lat("sub_zero", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, pk(64'd0, 1'b1, 1'b0, 1'b1));

    // Back-to-back stream with a randomly stalling consumer.
    sent = 0;
    cyc  = 0;
    while ((sent < 16 || exp_q.size() > 0) && cyc < 500) begin
      @(posedge clk); #1;
      ra = $urandom; rb = $urandom; rc = $urandom_range(0, 1); rs = $urandom_range(0, 1);
      bus.a = ra; bus.b = rb; bus.cin = rc; bus.sub = rs;
      bus.in_valid  = (sent < 16);
      bus.out_ready = $urandom_range(0, 1);
      @(negedge clk);
      chk_eq("in_ready_rule", {66'd0, bus.in_ready}, {66'd0, !(bus.out_valid && !bus.out_ready)});
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model({32'd0, ra}, {32'd0, rb}, rc, rs, 32));
        sent++;
      end
      cyc++;
    end
    chk_eq("stream_drained", 67'(exp_q.size() + (16 - sent)), 67'd0);

    // Three operands in flight, then a one-cycle reset.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.a = $urandom; bus.b = $urandom; bus.cin = 1'b0; bus.sub = 1'b0;
      @(negedge clk);
      chk_eq("flight_accept", {66'd0, bus.in_ready}, 67'd1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk_eq("rst_flush_valid", {66'd0, bus.out_valid}, 67'd0);
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) stale++;
    end
    chk_eq("rst_no_stale", 67'(stale), 67'd0);
    send_lat("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
             pk(64'h2345_6789, 1'b0, 1'b0, 1'b0));

    cyc = 0;
    while (done_x < NX && cyc < 40000) begin
      @(posedge clk);
      cyc++;
    end
    chk_eq("shapes_finished", 67'(done_x), 67'(NX));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // ---------------- other shapes, random ops vs model ----------------
  for (genvar gi = 0; gi < NX; gi++) begin : g_cfg
    localparam int W = CFG_W[gi];
    localparam int S = CFG_S[gi];

    cla_pipe_addsub_if #(.WIDTH(W)) bx ();
    cla_pipe_addsub #(.WIDTH(W), .STAGES(S)) dut_x (.clk(clk), .rst(rst_x), .bus(bx));

    logic [66:0] q [$];

    initial begin
      int          sent;
      int          cyc;
      logic [63:0] ra;
      logic [63:0] rb;
      logic [63:0] s64;
      logic        rc;
      logic        rs;
      sent = 0;
      cyc  = 0;
      bx.in_valid = 1'b0; bx.out_ready = 1'b1;
      bx.a = '0; bx.b = '0; bx.cin = 1'b0; bx.sub = 1'b0;
      @(negedge clk);
      while (rst_x && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      cyc = 0;
      while ((sent < N_OPS_X || q.size() > 0) && cyc < 35000) begin
        @(posedge clk); #1;
        ra = rnd64(W); rb = rnd64(W);
        rc = $urandom_range(0, 1); rs = $urandom_range(0, 1);
        bx.a = ra[W-1:0]; bx.b = rb[W-1:0]; bx.cin = rc; bx.sub = rs;
        bx.in_valid  = (sent < N_OPS_X) && ($urandom_range(0, 3) != 0);
        bx.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (bx.out_valid && bx.out_ready) begin
          s64 = '0;
          s64[W-1:0] = bx.sum;
          if (q.size() == 0) chk_eq($sformatf("w%0d_s%0d_spurious", W, S),
                                    {66'd0, bx.out_valid}, 67'd0);
          else chk_eq($sformatf("w%0d_s%0d_result", W, S),
                      pk(s64, bx.cout, bx.ovf, bx.zero), q.pop_front());
        end
        if (bx.in_valid && bx.in_ready) begin
          q.push_back(model(ra, rb, rc, rs, W));
          sent++;
        end
        cyc++;
      end
      chk_eq($sformatf("w%0d_s%0d_drained", W, S), 67'(q.size() + (N_OPS_X - sent)), 67'd0);
      done_x++;
    end
  end

endmodule
